// File: rtl/alu_result_collector.sv
// alu_result_collector: first-word-fall-through FIFO for ALU results.
// Each entry stores the result, its opcode, and zero/overflow flags that are
// computed when the entry is pushed. A sticky flag records whether any
// overflowing entry has been accepted since reset or since the last clr.
//
// Handshake: a push happens on a rising edge where in_valid && in_ready, and
// a pop happens on a rising edge where out_valid && out_ready. in_ready
// depends only on occupancy, never on out_ready, so a full FIFO refuses a
// push even when the head is popped on the same edge. out_ready is ignored
// while out_valid is low, and in_result/in_opsel are ignored without a push.
module alu_result_collector #(
   parameter int WIDTH     = 8,
   parameter int MUL_WIDTH = 16,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [MUL_WIDTH-1:0]     in_result,
   input  logic [3:0]               in_opsel,
   input  logic                     clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [MUL_WIDTH-1:0]     out_result,
   output logic [3:0]               out_opsel,
   output logic                     out_zero,
   output logic                     out_ovf,
   output logic                     ovf_sticky,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Entry storage; contents are only meaningful below the occupancy count.
   logic [MUL_WIDTH-1:0] mem_result [DEPTH];
   logic [3:0]           mem_opsel  [DEPTH];
   logic                 mem_zero   [DEPTH];
   logic                 mem_ovf    [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;

   logic push;
   logic pop;
   logic in_zero;
   logic in_ovf_op;
   logic in_ovf;
   logic [MUL_WIDTH-WIDTH-1:0] in_upper;

   // Full and empty come from the occupancy count, not from pointer compares.
   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // Flags for the incoming entry. Only add, sub and shift-left can overflow
   // the operand width; multiply legitimately produces a full-width result.
   assign in_upper  = in_result[MUL_WIDTH-1:WIDTH];
   assign in_zero   = (in_result == '0);
   assign in_ovf_op = (in_opsel == 4'd0) || (in_opsel == 4'd1) || (in_opsel == 4'd4);
   assign in_ovf    = in_ovf_op && (in_upper != '0);

   // Head entry is read straight from storage; data outputs are forced to 0
   // when there is no valid head.
   assign out_result = out_valid ? mem_result[rd_ptr] : '0;
   assign out_opsel  = out_valid ? mem_opsel[rd_ptr]  : '0;
   assign out_zero   = out_valid ? mem_zero[rd_ptr]   : 1'b0;
   assign out_ovf    = out_valid ? mem_ovf[rd_ptr]    : 1'b0;

   // Write the pushed entry and its flags into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr] <= in_result;
         mem_opsel[wr_ptr]  <= in_opsel;
         mem_zero[wr_ptr]   <= in_zero;
         mem_ovf[wr_ptr]    <= in_ovf;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow: a push carrying ovf takes priority over a same-edge clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (push && in_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (clr) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed and randomized checks of the result
// collector against a queue-based reference model.
module tb_alu_result_collector;

   localparam int WIDTH     = 8;
   localparam int MUL_WIDTH = 16;
   localparam int DEPTH     = 4;
   localparam int CW        = $clog2(DEPTH) + 1;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [MUL_WIDTH-1:0] in_result;
   logic [3:0]           in_opsel;
   logic                 clr;
   logic                 out_valid;
   logic                 out_ready;
   logic [MUL_WIDTH-1:0] out_result;
   logic [3:0]           out_opsel;
   logic                 out_zero;
   logic                 out_ovf;
   logic                 ovf_sticky;
   logic [CW-1:0]        count;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: queue of {opsel, result} in push order plus sticky bit.
   logic [MUL_WIDTH+3:0] exp_q[$];
   bit                   exp_sticky = 1'b0;

   alu_result_collector #(
      .WIDTH(WIDTH), .MUL_WIDTH(MUL_WIDTH), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_opsel(in_opsel),
      .clr(clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_opsel(out_opsel),
      .out_zero(out_zero), .out_ovf(out_ovf),
      .ovf_sticky(ovf_sticky), .count(count)
   );

   // Clock: period 10, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_ovf(input logic [MUL_WIDTH-1:0] r, input logic [3:0] op);
      return (op == 4'd0 || op == 4'd1 || op == 4'd4) && ((r >> WIDTH) != 0);
   endfunction

   // Model update on each edge from the inputs that were stable before it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_sticky = 1'b0;
      end else begin
         bit m_push, m_pop;
         m_push = in_valid && (exp_q.size() < DEPTH);
         m_pop  = out_ready && (exp_q.size() > 0);
         if (m_pop) void'(exp_q.pop_front());
         if (m_push) exp_q.push_back({in_opsel, in_result});
         if (m_push && model_ovf(in_result, in_opsel)) exp_sticky = 1'b1;
         else if (clr) exp_sticky = 1'b0;
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      bit                   ev;
      logic [MUL_WIDTH+3:0] h;
      logic [MUL_WIDTH-1:0] hr;
      logic [3:0]           ho;
      ev = (exp_q.size() > 0);
      h  = ev ? exp_q[0] : '0;
      hr = h[MUL_WIDTH-1:0];
      ho = h[MUL_WIDTH+3:MUL_WIDTH];
      check("out_valid",  out_valid, ev);
      check("in_ready",   in_ready, exp_q.size() < DEPTH);
      check("count",      count, exp_q.size());
      check("ovf_sticky", ovf_sticky, exp_sticky);
      check("out_result", out_result, hr);
      check("out_opsel",  out_opsel, ho);
      check("out_zero",   out_zero, ev && (hr == 0));
      check("out_ovf",    out_ovf, ev && model_ovf(hr, ho));
   end

   // Driver: apply one set of inputs across the next rising edge.
   task automatic step(input bit v, input logic [MUL_WIDTH-1:0] r, input logic [3:0] op,
                       input bit ordy, input bit c);
      in_valid  = v;
      in_result = r;
      in_opsel  = op;
      out_ready = ordy;
      clr       = c;
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 4'd0, 1'b1, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_opsel  = '0;
      clr       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", count, 0);
      check("rst_sticky", ovf_sticky, 0);
      check("rst_out_result", out_result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Add with overflow into an otherwise idle FIFO
      step(1'b1, 16'h0105, 4'd0, 1'b0, 1'b0);
      check("t1_out_valid", out_valid, 1);
      check("t1_out_result", out_result, 16'h0105);
      check("t1_out_ovf", out_ovf, 1);
      check("t1_out_zero", out_zero, 0);
      check("t1_sticky", ovf_sticky, 1);
      check("t1_count", count, 1);
      step(1'b0, '0, 4'd0, 1'b1, 1'b0);
      check("t1_count_after_pop", count, 0);

      // Multiply never flags overflow; zero result flags zero
      step(1'b1, 16'h0F00, 4'd2, 1'b0, 1'b0);
      step(1'b1, 16'h0000, 4'd7, 1'b0, 1'b0);
      check("t2_head_result", out_result, 16'h0F00);
      check("t2_head_ovf", out_ovf, 0);
      check("t2_head_zero", out_zero, 0);
      step(1'b0, '0, 4'd0, 1'b1, 1'b0);
      check("t2_second_result", out_result, 16'h0000);
      check("t2_second_opsel", out_opsel, 4'd7);
      check("t2_second_ovf", out_ovf, 0);
      check("t2_second_zero", out_zero, 1);
      step(1'b0, '0, 4'd0, 1'b1, 1'b0);

      // Fill to DEPTH, then a push waits for the pop edge to free a slot
      for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0010 + 16'(i), 4'd3, 1'b0, 1'b0);
      check("t3_full_count", count, DEPTH);
      check("t3_full_in_ready", in_ready, 0);
      step(1'b1, 16'h00AA, 4'd3, 1'b1, 1'b0);
      check("t3_pop_no_push_count", count, DEPTH - 1);
      check("t3_head_after_pop", out_result, 16'h0011);
      step(1'b1, 16'h00AA, 4'd3, 1'b0, 1'b0);
      check("t3_refill_count", count, DEPTH);
      drain();
      check("t3_drained", count, 0);

      // Streaming at count=2 across several pointer wraps
      step(1'b1, 16'h1000, 4'd5, 1'b0, 1'b0);
      step(1'b1, 16'h1001, 4'd5, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 16'h1002 + 16'(i), 4'd5, 1'b1, 1'b0);
         check("t4_stream_count", count, 2);
         check("t4_stream_head", out_result, 16'h1001 + 16'(i));
      end
      drain();

      // clr against a same-edge overflowing push
      step(1'b0, '0, 4'd0, 1'b0, 1'b1);
      check("t5_clr_alone", ovf_sticky, 0);
      step(1'b1, 16'h0200, 4'd1, 1'b0, 1'b1);
      check("t5_set_wins", ovf_sticky, 1);
      step(1'b0, '0, 4'd0, 1'b0, 1'b1);
      check("t5_clr_after", ovf_sticky, 0);
      step(1'b1, 16'h0100, 4'd4, 1'b0, 1'b0);
      step(1'b1, 16'hFF00, 4'd3, 1'b0, 1'b0);
      drain();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [MUL_WIDTH-1:0] r;
         case ($urandom_range(0, 3))
            0:       r = '0;
            1:       r = MUL_WIDTH'($urandom_range(0, 255));
            default: r = MUL_WIDTH'($urandom_range(0, 16'hFFFF));
         endcase
         step($urandom_range(0, 2) != 0, r, 4'($urandom_range(0, 15)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      end
      drain();

      // Asynchronous reset between edges with entries stored
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0300 + 16'(i), 4'd0, 1'b0, 1'b0);
      check("t7_count3", count, 3);
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("t7_rst_out_valid", out_valid, 0);
      check("t7_rst_count", count, 0);
      check("t7_rst_in_ready", in_ready, 1);
      check("t7_rst_out_result", out_result, 0);
      check("t7_rst_sticky", ovf_sticky, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      step(1'b1, 16'h0042, 4'd6, 1'b0, 1'b0);
      check("t7_first_after_rst", out_result, 16'h0042);
      check("t7_count_after_rst", count, 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: ALU operand width.
REQ-002 The block SHALL have parameter MUL_WIDTH, default 16: ALU result width.
REQ-003 The block SHALL have parameter DEPTH, default 4: FIFO entries, power of two, minimum 2.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream ALU result valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: collector can accept an entry.
REQ-008 The block SHALL have port in_result, input, MUL_WIDTH bits: ALU result.
REQ-009 The block SHALL have port in_opsel, input, 4 bits: opcode that produced in_result.
REQ-010 The block SHALL have port clr, input, 1 bit: synchronous clear of the sticky flag.
REQ-011 The block SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the head entry.
REQ-013 The block SHALL have port out_result, output, MUL_WIDTH bits: head result.
REQ-014 The block SHALL have port out_opsel, output, 4 bits: head opcode.
REQ-015 The block SHALL have port out_zero, output, 1 bit: head result equals 0.
REQ-016 The block SHALL have port out_ovf, output, 1 bit: head result exceeds WIDTH bits.
REQ-017 The block SHALL have port ovf_sticky, output, 1 bit: an overflowing entry has been accepted since reset or clr.
REQ-018 The block SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-019 Push SHALL occur on a clock edge with in_valid=1 and in_ready=1; pop SHALL occur on a clock edge with out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL be 1 when count<DEPTH, and SHALL NOT depend combinationally on out_ready; a push while full SHALL be impossible, even with a same-cycle pop.
REQ-021 out_valid SHALL be 1 when count>0; FIFO SHALL be first-word-fall-through: the head entry is visible in the cycle after its push edge, with zero extra latency.
REQ-022 While out_valid=0, out_result, out_opsel, out_zero and out_ovf SHALL be driven 0.
REQ-023 Flags SHALL be computed at push time from in_result/in_opsel and stored with the entry: zero = (in_result==0).
REQ-024 ovf SHALL be 1 iff in_opsel is 0 (add), 1 (sub) or 4 (shift left) and in_result[MUL_WIDTH-1:WIDTH] is nonzero; ovf SHALL be 0 for every other opsel, including 2 (multiply).
REQ-025 Simultaneous push and pop SHALL leave count unchanged, with entries in order; a pop of the last entry and a push on the same edge SHALL make the new entry the head in the next cycle.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; full/empty SHALL be derived from count.
REQ-027 ovf_sticky SHALL be set on the edge that pushes an entry with ovf=1.
REQ-028 clr=1 SHALL clear ovf_sticky on the next edge; if a push with ovf=1 occurs on the same edge, set SHALL win and ovf_sticky SHALL be 1.
REQ-029 in_result and in_opsel SHALL be ignored when no push occurs; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-030 rst_n=0 SHALL immediately and asynchronously set count=0, pointers=0, ovf_sticky=0, out_valid=0 and in_ready=1, with all out_* data and flag outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; the first push after release SHALL be the first entry popped.
REQ-032 Storage contents need not be reset.

Verification
REQ-033 The bench SHALL push opsel=0 result=0x0105 with out_ready=0, and require: next cycle out_valid=1, out_result=0x0105, out_ovf=1, out_zero=0, ovf_sticky=1, count=1.
REQ-034 The bench SHALL push opsel=2 result=0x0F00 and then opsel=7 result=0x0000, and require out_ovf=0 for both, out_zero=0 then 1, popped in order.
REQ-035 The bench SHALL hold out_ready=0 and push DEPTH=4 entries, and require count=4, in_ready=0; a fifth in_valid with out_ready=1 SHALL be accepted only on the edge after the pop.
REQ-036 With count=2, the bench SHALL assert in_valid and out_ready together for 10 cycles, and require count to stay 2, data to exit in push order and pointers to wrap correctly.
REQ-037 The bench SHALL assert clr and push an ovf entry on the same edge, and require ovf_sticky=1; a following clr alone SHALL give ovf_sticky=0.
REQ-038 With count=3, the bench SHALL pull rst_n low between clock edges, and require out_valid=0, count=0 and in_ready=1 before the next edge.
